// File: rtl/edge_pattern_gen_pkg.sv
// Shared types and defaults for the edge pattern generator.
// Detector benches import the same state encoding.
package edge_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam int unsigned LEN_W_DEF = 8;
  localparam int unsigned NUM_W_DEF = 8;

endpackage

// File: rtl/edge_gen_cnt.sv
// Phase-length down-counter with synchronous load and zero flag.
// Saturates at zero instead of wrapping.
module edge_gen_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/edge_pattern_gen.sv
// Programmable pulse-train generator: H cycles high, L cycles low,
// repeated N times, with start/busy/done handshake and abort.
module edge_pattern_gen
  import edge_pattern_gen_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF,
  parameter int unsigned NUM_W = NUM_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [LEN_W-1:0] high_len,
  input  logic [LEN_W-1:0] low_len,
  input  logic [NUM_W-1:0] num_pulses,
  input  logic             abort,
  output logic             d_out,
  output logic             busy,
  output logic             done,
  output logic             fall_mark
);

  state_e           state_q;
  logic [LEN_W-1:0] hlen_q;
  logic [LEN_W-1:0] llen_q;
  logic [NUM_W-1:0] pulses_q;
  logic             d_out_q;
  logic             busy_q;
  logic             done_q;
  logic             fall_q;

  logic [LEN_W-1:0] hi_in;
  logic [LEN_W-1:0] lo_in;
  logic             go;
  logic             cnt_ld;
  logic [LEN_W-1:0] cnt_ld_val;
  logic             cnt_dec;
  logic             cnt_zero;

  // Zero lengths behave as one cycle so every phase is visible.
  assign hi_in = (high_len == '0) ? LEN_W'(1) : high_len;
  assign lo_in = (low_len == '0) ? LEN_W'(1) : low_len;
  assign go    = start && !abort && (num_pulses != '0);

  always_comb begin
    cnt_ld     = 1'b0;
    cnt_ld_val = '0;
    cnt_dec    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          cnt_ld     = 1'b1;
          cnt_ld_val = hi_in - LEN_W'(1);
        end
      end
      ST_HIGH: begin
        if (abort) begin
          cnt_ld = 1'b1;
        end else if (cnt_zero) begin
          cnt_ld     = 1'b1;
          cnt_ld_val = llen_q - LEN_W'(1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_LOW: begin
        if (abort) begin
          cnt_ld = 1'b1;
        end else if (cnt_zero) begin
          cnt_ld = 1'b1;
          if (pulses_q > NUM_W'(1)) begin
            cnt_ld_val = hlen_q - LEN_W'(1);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: cnt_ld = 1'b1;
    endcase
  end

  edge_gen_cnt #(
    .W(LEN_W)
  ) u_cnt (
    .clk       (clk),
    .rstn      (rstn),
    .load_i    (cnt_ld),
    .load_val_i(cnt_ld_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      hlen_q   <= '0;
      llen_q   <= '0;
      pulses_q <= '0;
      d_out_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (go) begin
            state_q  <= ST_HIGH;
            hlen_q   <= hi_in;
            llen_q   <= lo_in;
            pulses_q <= num_pulses;
            d_out_q  <= 1'b1;
            busy_q   <= 1'b1;
          end else if (start && !abort) begin
            done_q <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (abort) begin
            state_q  <= ST_IDLE;
            pulses_q <= '0;
            d_out_q  <= 1'b0;
            busy_q   <= 1'b0;
            fall_q   <= 1'b1;
          end else if (cnt_zero) begin
            state_q <= ST_LOW;
            d_out_q <= 1'b0;
            fall_q  <= 1'b1;
          end
        end
        ST_LOW: begin
          if (abort) begin
            state_q  <= ST_IDLE;
            pulses_q <= '0;
            busy_q   <= 1'b0;
          end else if (cnt_zero) begin
            if (pulses_q > NUM_W'(1)) begin
              state_q  <= ST_HIGH;
              pulses_q <= pulses_q - NUM_W'(1);
              d_out_q  <= 1'b1;
            end else begin
              state_q  <= ST_IDLE;
              pulses_q <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          d_out_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign d_out     = d_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fall_mark = fall_q;

endmodule

// File: tb/tb_edge_pattern_gen.sv
// Bench for edge_pattern_gen: waveform model from period lists,
// directed scenarios plus randomized trains with random aborts.
module tb_edge_pattern_gen;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] high_len = '0;
  logic [7:0] low_len = '0;
  logic [7:0] num_pulses = '0;
  logic       d_out;
  logic       busy;
  logic       done;
  logic       fall_mark;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic       prev_d = 1'b0;
  logic [15:0] dhist = '0;
  logic [9:0] want_t2 = 10'b1100011000;
  // Expected per-cycle {d_out, busy, done, fall_mark}
  logic [3:0] expq[$];

  always #5 clk = ~clk;

  edge_pattern_gen dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .high_len  (high_len),
    .low_len   (low_len),
    .num_pulses(num_pulses),
    .abort     (abort),
    .d_out     (d_out),
    .busy      (busy),
    .done      (done),
    .fall_mark (fall_mark)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] got;
    logic       ned;
    got = {d_out, busy, done, fall_mark};
    ned = prev_d & ~d_out;
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
    n_cmp++;
    assert (fall_mark === ned) else begin
      n_bad++;
      $error("FAIL %s_nedge got=%b exp=%b", tag, fall_mark, ned);
    end
    prev_d = d_out;
    dhist  = {dhist[14:0], d_out};
  endtask

  task automatic gen(input int h, input int l, input int n);
    int hh;
    int ll;
    hh = (h == 0) ? 1 : h;
    ll = (l == 0) ? 1 : l;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < hh; i++) expq.push_back(4'b1100);
      for (int i = 0; i < ll; i++)
        expq.push_back((i == 0) ? 4'b0101 : 4'b0100);
    end
    expq.push_back(4'b0010);
  endtask

  task automatic launch(input int h, input int l, input int n);
    high_len   = 8'(h);
    low_len    = 8'(l);
    num_pulses = 8'(n);
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic play(input int ab, input int rs, input int rh,
                      input int rl, input int rn, input string tag);
    int         i;
    logic [3:0] e;
    i = 0;
    while (expq.size() != 0) begin
      e = expq.pop_front();
      i++;
      chk(tag, e);
      if (i == ab) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk({tag, "_abort"}, {3'b000, e[3]});
        expq.delete();
        tick();
        chk({tag, "_idle"}, 4'b0000);
        return;
      end
      if (i == rs) begin
        high_len   = 8'(rh);
        low_len    = 8'(rl);
        num_pulses = 8'(rn);
        start      = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    int h;
    int l;
    int n;
    int tot;
    int ab;

    tick();
    tick();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("reset_idle", 4'b0000);
    end

    gen(2, 3, 2);
    launch(2, 3, 2);
    play(0, 0, 0, 0, 0, "t2");
    n_cmp++;
    assert (dhist[10:1] === want_t2) else begin
      n_bad++;
      $error("FAIL t2_wave got=%b exp=%b", dhist[10:1], want_t2);
    end

    gen(4, 4, 0);
    launch(4, 4, 0);
    play(0, 0, 0, 0, 0, "n0");
    chk("n0_after", 4'b0000);

    gen(0, 0, 1);
    launch(0, 0, 1);
    play(0, 0, 0, 0, 0, "h0l0");

    gen(4, 4, 3);
    launch(4, 4, 3);
    play(2, 0, 0, 0, 0, "abort_h");

    high_len   = 8'd3;
    low_len    = 8'd3;
    num_pulses = 8'd2;
    start      = 1'b1;
    abort      = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("start_abort", 4'b0000);
      tick();
    end

    gen(3, 2, 2);
    tot = expq.size();
    launch(3, 2, 2);
    high_len   = 8'd7;
    low_len    = 8'd7;
    num_pulses = 8'd5;
    start      = 1'b1;
    play(0, tot, 1, 4, 1, "b2b_a");
    start = 1'b0;
    gen(1, 4, 1);
    play(0, 0, 0, 0, 0, "b2b_b");

    gen(255, 255, 1);
    launch(255, 255, 1);
    play(0, 0, 0, 0, 0, "maxlen");

    for (int k = 0; k < 25; k++) begin
      h = int'($urandom_range(0, 5));
      l = int'($urandom_range(0, 5));
      n = int'($urandom_range(0, 3));
      gen(h, l, n);
      tot = expq.size();
      ab = 0;
      if (n != 0 && $urandom_range(0, 1) == 1)
        ab = int'($urandom_range(1, tot - 1));
      launch(h, l, n);
      play(ab, 0, 0, 0, 0, "rand");
      chk("rand_gap", 4'b0000);
    end

    launch(2, 3, 2);
    tick();
    tick();
    tick();
    #3 rstn = 1'b0;
    #1;
    n_cmp++;
    assert ({d_out, busy, done, fall_mark} === 4'b0000) else begin
      n_bad++;
      $error("FAIL rst_low got=%b exp=%b",
             {d_out, busy, done, fall_mark}, 4'b0000);
    end
    prev_d = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    launch(4, 4, 1);
    tick();
    #3 rstn = 1'b0;
    #1;
    n_cmp++;
    assert ({d_out, busy, done, fall_mark} === 4'b0000) else begin
      n_bad++;
      $error("FAIL rst_high got=%b exp=%b",
             {d_out, busy, done, fall_mark}, 4'b0000);
    end
    prev_d = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    gen(2, 3, 2);
    launch(2, 3, 2);
    play(0, 0, 0, 0, 0, "t6");
    n_cmp++;
    assert (dhist[10:1] === want_t2) else begin
      n_bad++;
      $error("FAIL t6_wave got=%b exp=%b", dhist[10:1], want_t2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
